// File: rtl/rx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_arbiter
// Description : Frame-granular round-robin arbiter feeding one parser chain
//               from NUM_PORTS ingress beat streams, with length truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_arbiter #(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_PORTS  = 2,
    parameter  int MAX_BEATS  = 190,
    localparam int IDXW       = $clog2(DATA_WIDTH / 8),
    localparam int PW         = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*IDXW-1:0]       s_idx,
    input  logic [NUM_PORTS-1:0]            s_valid,
    input  logic [NUM_PORTS-1:0]            s_last,
    output logic [NUM_PORTS-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [IDXW-1:0]                 m_idx,
    output logic                            m_valid,
    output logic                            m_last,
    input  logic                            m_ready,
    output logic [PW-1:0]                   m_port,
    output logic                            m_first,
    output logic                            trunc_err,
    output logic                            busy
);

    localparam int c_CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MAX_BEATS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FWD  = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    logic [1:0]            r_state;
    logic [PW-1:0]         r_grant;
    logic [PW-1:0]         r_rr_ptr;
    logic [c_CNT_W-1:0]    r_beat_cnt;
    logic                  r_trunc_err;

    logic [1:0]            w_state_nxt;
    logic                  w_req_any;
    logic                  w_hi_found;
    logic [PW-1:0]         w_hi_sel;
    logic [PW-1:0]         w_lo_sel;
    logic [PW-1:0]         w_grant_sel;
    logic [NUM_PORTS-1:0]  w_grant_onehot;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_tdata;
    logic [IDXW-1:0]       w_sel_idx;
    logic                  w_at_limit;
    logic                  w_xfer;

    // Granted-port mux
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_tdata = '0;
        w_sel_idx   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(r_grant) == p) begin
                w_sel_valid = s_valid[p];
                w_sel_last  = s_last[p];
                w_sel_tdata = s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                w_sel_idx   = s_idx[p*IDXW +: IDXW];
            end
        end
    end

    // Round-robin: lowest requester above rr_ptr, else lowest at/below it.
    // Searching real port numbers only means unused codes are never chosen.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_sel   = '0;
        w_lo_sel   = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (s_valid[p]) begin
                if (p > int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_sel   = PW'(p);
                end else begin
                    w_lo_sel   = PW'(p);
                end
            end
        end
        w_grant_sel = w_hi_found ? w_hi_sel : w_lo_sel;
    end

    assign w_req_any      = |s_valid;
    assign w_grant_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant;
    assign w_at_limit     = (r_beat_cnt == c_LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        s_ready     = '0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_first     = 1'b0;
        m_tdata     = '0;
        m_idx       = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req_any) w_state_nxt = c_ST_FWD;
            end
            c_ST_FWD: begin
                m_valid = w_sel_valid;
                m_tdata = w_sel_tdata;
                m_idx   = w_sel_idx;
                m_last  = w_sel_valid & (w_sel_last | w_at_limit);
                m_first = (r_beat_cnt == '0);
                s_ready = w_grant_onehot & {NUM_PORTS{m_ready}};
                w_xfer  = w_sel_valid & m_ready;
                if (w_xfer) begin
                    if (w_sel_last)      w_state_nxt = c_ST_IDLE;
                    else if (w_at_limit) w_state_nxt = c_ST_DROP;
                end
            end
            c_ST_DROP: begin
                s_ready = w_grant_onehot;
                if (w_sel_valid && w_sel_last) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= PW'(NUM_PORTS - 1);
            r_beat_cnt  <= '0;
            r_trunc_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_trunc_err <= w_xfer & ~w_sel_last & w_at_limit;
            if (r_state == c_ST_IDLE && w_req_any) begin
                r_grant    <= w_grant_sel;
                r_rr_ptr   <= w_grant_sel;
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign m_port    = r_grant;
    assign trunc_err = r_trunc_err;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_arbiter
// Description : Directed bench for rx_frame_arbiter with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_arbiter;

    localparam int DW = 64;
    localparam int NP = 2;
    localparam int MB = 4;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  idx;
        logic        last;
    } sbeat_t;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  idx;
        logic        last;
        logic        first;
        int          port;
    } obeat_t;

    typedef struct {
        int          port;
        int          n;
        logic [2:0]  lidx;
        logic [63:0] base;
    } frame_t;

    localparam int C_CONT_REL[8]  = '{1, 2, 4, 5, 7, 8, 10, 11};
    localparam int C_CONT_PORT[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    localparam int C_BP_REL[4]    = '{1, 4, 5, 6};

    logic                 clk;
    logic                 rst;
    logic [NP*DW-1:0]     s_tdata;
    logic [NP*3-1:0]      s_idx;
    logic [NP-1:0]        s_valid;
    logic [NP-1:0]        s_last;
    logic [NP-1:0]        s_ready;
    logic [DW-1:0]        m_tdata;
    logic [2:0]           m_idx;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;
    logic [0:0]           m_port;
    logic                 m_first;
    logic                 trunc_err;
    logic                 busy;

    sbeat_t q0[$];
    sbeat_t q1[$];
    frame_t pend[$];
    obeat_t exp_q[$];
    int     xfer_cyc[$];
    int     xfer_port[$];
    int     xfer_idx[$];
    int     xfer_last[$];
    int     trunc_q[$];
    int     exp_trunc;
    int     m_rr;
    int     n_chk = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     t0;
    logic   chk_en;
    obeat_t cmp_h;

    rx_frame_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_idx(s_idx), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready),
        .m_tdata(m_tdata), .m_idx(m_idx), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .m_port(m_port), .m_first(m_first),
        .trunc_err(trunc_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Queue a frame on a source and remember it for the model
    function automatic void add_frame(int p, int n, logic [2:0] lidx, logic [63:0] base);
        sbeat_t b;
        frame_t f;
        for (int k = 0; k < n; k++) begin
            b.data = base + 64'(k);
            b.idx  = (k == n - 1) ? lidx : 3'd7;
            b.last = (k == n - 1);
            if (p == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
        f.port = p; f.n = n; f.lidx = lidx; f.base = base;
        pend.push_back(f);
    endfunction

    // Frame-level model: serve pending frames round-robin, clip to MB beats
    function automatic void plan();
        frame_t f;
        obeat_t o;
        int     pick;
        int     nout;
        while (pend.size() > 0) begin
            pick = -1;
            for (int i = 1; i <= NP && pick < 0; i++) begin
                for (int j = 0; j < pend.size() && pick < 0; j++) begin
                    if (pend[j].port == (m_rr + i) % NP) pick = j;
                end
            end
            f = pend[pick];
            pend.delete(pick);
            nout = (f.n > MB) ? MB : f.n;
            for (int k = 0; k < nout; k++) begin
                o.data  = f.base + 64'(k);
                o.idx   = (k == f.n - 1) ? f.lidx : 3'd7;
                o.last  = (k == nout - 1);
                o.first = (k == 0);
                o.port  = f.port;
                exp_q.push_back(o);
            end
            if (f.n > MB) exp_trunc++;
            m_rr = f.port;
        end
    endfunction

    task automatic drive();
        s_valid = '0; s_last = '0; s_tdata = '0; s_idx = '0;
        if (q0.size() > 0) begin
            s_valid[0] = 1'b1; s_last[0] = q0[0].last;
            s_tdata[63:0] = q0[0].data; s_idx[2:0] = q0[0].idx;
        end
        if (q1.size() > 0) begin
            s_valid[1] = 1'b1; s_last[1] = q1[0].last;
            s_tdata[127:64] = q1[0].data; s_idx[5:3] = q1[0].idx;
        end
    endtask

    task automatic tick();
        logic [NP-1:0] hs;
        @(negedge clk);
        hs = s_valid & s_ready;
        @(posedge clk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic start_test();
        xfer_cyc.delete(); xfer_port.delete(); xfer_idx.delete();
        xfer_last.delete(); trunc_q.delete();
        exp_trunc = 0;
    endtask

    task automatic launch();
        plan();
        drive();
        t0 = cyc;
    endtask

    task automatic run_to_idle(input int maxc);
        int n;
        n = 0;
        tick();
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || busy) && n < maxc) begin
            tick();
            n++;
        end
        check("idle_timeout", n < maxc, 1);
        check("beats_left", exp_q.size(), 0);
        check("trunc_count", trunc_q.size(), exp_trunc);
    endtask

    // Compare process: every cycle a beat is presented it must match the model head
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready_onehot", ($countones(s_ready) <= 1), 1);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_valid, 0);
                end else begin
                    cmp_h = exp_q[0];
                    check("m_tdata", m_tdata, cmp_h.data);
                    check("m_idx",   m_idx,   cmp_h.idx);
                    check("m_last",  m_last,  cmp_h.last);
                    check("m_first", m_first, cmp_h.first);
                    check("m_port",  m_port,  cmp_h.port);
                    check("s_ready", s_ready, m_ready ? (64'(1) << cmp_h.port) : 64'(0));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cyc.push_back(cyc);
                        xfer_port.push_back(int'(m_port));
                        xfer_idx.push_back(int'(m_idx));
                        xfer_last.push_back(int'(m_last));
                    end
                end
            end
            if (trunc_err) trunc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; chk_en = 1'b0; m_ready = 1'b1; m_rr = NP - 1;
        s_valid = '0; s_last = '0; s_tdata = '0; s_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_first", m_first, 0);
        check("rst_trunc", trunc_err, 0);
        check("rst_busy", busy, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_port", m_port, 0);
        rst = 1'b0; chk_en = 1'b1;
        tick();

        // Contention: both ports hold two 2-beat frames
        start_test();
        add_frame(0, 2, 3'd6, 64'hA000_0000_0000_0000);
        add_frame(0, 2, 3'd6, 64'hA000_0000_0000_0100);
        add_frame(1, 2, 3'd5, 64'hB000_0001_0000_0000);
        add_frame(1, 2, 3'd5, 64'hB000_0001_0000_0100);
        launch();
        run_to_idle(40);
        check("cont_count", xfer_cyc.size(), 8);
        for (int i = 0; i < 8 && i < xfer_cyc.size(); i++) begin
            check("cont_rel_cycle", xfer_cyc[i] - t0, C_CONT_REL[i]);
            check("cont_port", xfer_port[i], C_CONT_PORT[i]);
        end

        // Single port, 3 beats
        start_test();
        add_frame(0, 3, 3'd3, 64'h1111_0000_0000_0000);
        launch();
        run_to_idle(20);
        check("single_count", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check("single_latency", xfer_cyc[0] - t0, 1);
            check("single_last_rel", xfer_cyc[2] - t0, 3);
            check("single_last_idx", xfer_idx[2], 3);
            check("single_last_flag", xfer_last[2], 1);
        end

        // Backpressure: ready 1,0,0,1 across a 4-beat frame
        start_test();
        add_frame(0, 4, 3'd5, 64'h2222_0000_0000_0000);
        launch();
        for (int k = 0; k < 10; k++) begin
            tick();
            m_ready = !((cyc - t0) == 2 || (cyc - t0) == 3);
        end
        m_ready = 1'b1;
        run_to_idle(10);
        check("bp_count", xfer_cyc.size(), 4);
        for (int i = 0; i < 4 && i < xfer_cyc.size(); i++)
            check("bp_rel_cycle", xfer_cyc[i] - t0, C_BP_REL[i]);

        // Boundary: last beat exactly at the limit
        start_test();
        add_frame(1, 4, 3'd0, 64'h3333_0000_0000_0000);
        launch();
        run_to_idle(20);
        check("bound_count", xfer_cyc.size(), 4);
        check("bound_trunc", trunc_q.size(), 0);
        check("bound_end_rel", cyc - t0, 5);

        // Truncation: 7-beat frame, 4 forwarded, 3 absorbed
        start_test();
        add_frame(1, 7, 3'd2, 64'h4444_0000_0000_0000);
        launch();
        run_to_idle(30);
        check("trunc_fwd_count", xfer_cyc.size(), 4);
        if (xfer_last.size() == 4) check("trunc_forced_last", xfer_last[3], 1);
        check("trunc_pulses", trunc_q.size(), 1);
        if (trunc_q.size() == 1) check("trunc_rel_cycle", trunc_q[0] - t0, 5);
        check("trunc_end_rel", cyc - t0, 8);

        // Reset mid-frame
        start_test();
        add_frame(0, 5, 3'd7, 64'h5555_0000_0000_0000);
        launch();
        n = 0;
        while (xfer_cyc.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("pre_rst_timeout", n < 20, 1);
        rst = 1'b1; chk_en = 1'b0;
        tick();
        check("midrst_s_ready", s_ready, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        q0.delete(); q1.delete(); exp_q.delete(); pend.delete();
        m_rr = NP - 1;
        rst = 1'b0; chk_en = 1'b1;
        start_test();
        add_frame(1, 2, 3'd4, 64'h6666_0001_0000_0000);
        add_frame(0, 2, 3'd4, 64'h6666_0000_0000_0000);
        launch();
        run_to_idle(30);
        check("postrst_count", xfer_cyc.size(), 4);
        if (xfer_cyc.size() > 0) begin
            check("postrst_first_port", xfer_port[0], 0);
            check("postrst_latency", xfer_cyc[0] - t0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_frame_arbiter.md
Name: rx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the single Ethernet/IPv4/L4 parser chain between NUM_PORTS ingress byte-stream sources.
- Sits between the RX MAC/DMA ports and the Ethernet parser.
- Holds a grant from the first beat to the last beat of a frame and tags output beats with the source port.
- Truncates frames that exceed MAX_BEATS so a runaway source cannot starve the chain.

Parameters:
- DATA_WIDTH, 64, beat width in bits; a multiple of 8.
- NUM_PORTS, 2, number of ingress sources; 2..8.
- MAX_BEATS, 190, maximum beats forwarded per frame (1518 B at 8 B/beat, rounded up).
- Derived: IDXW = $clog2(DATA_WIDTH/8); PW = max(1, $clog2(NUM_PORTS)).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port beat data; port p occupies [p*DATA_WIDTH +: DATA_WIDTH].
- s_idx  in  NUM_PORTS*IDXW  per-port index of the last valid byte in the beat.
- s_valid  in  NUM_PORTS  per-port beat valid.
- s_last  in  NUM_PORTS  per-port last beat of frame.
- s_ready  out  NUM_PORTS  per-port beat accepted when valid & ready.
- m_tdata  out  DATA_WIDTH  beat to the Ethernet parser.
- m_idx  out  IDXW  last valid byte index.
- m_valid  out  1  output beat valid.
- m_last  out  1  last beat, natural or forced.
- m_ready  in  1  downstream accept.
- m_port  out  PW  granted source port; stable for the whole frame.
- m_first  out  1  high on the first beat of a frame; the parsers clear their header state on it.
- trunc_err  out  1  one-cycle pulse when a frame is truncated.
- busy  out  1  high in FWD or DROP.

Behaviour:
- States: IDLE, FWD, DROP.
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=NUM_PORTS-1 (port 0 wins first), beat_cnt=0, grant=0.
  - trunc_err=0; all s_ready=0; m_valid=0, m_last=0, m_first=0.
  - m_tdata/m_idx/m_port are don't-care while m_valid=0, but are driven to 0 in reset.
- Reset mid-frame: the in-flight frame is abandoned with no forced m_last. Downstream recovers on the next m_first.
- IDLE:
  - All s_ready=0, m_valid=0.
  - If any s_valid is high, grant the first requesting port searching rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS.
  - Register the grant, set rr_ptr=grant, beat_cnt=0, go to FWD.
  - This costs one cycle of arbitration bubble per frame.
- FWD:
  - Combinational passthrough: m_tdata/m_idx/m_valid from the granted port; s_ready[grant]=m_ready; other s_ready=0.
  - m_port=grant; m_first = (beat_cnt==0).
  - A transfer is m_valid & m_ready; beat_cnt increments on each transfer.
  - Transfer with s_last: m_last=1; go to IDLE.
  - Transfer with beat_cnt==MAX_BEATS-1 and no s_last: m_last forced to 1; trunc_err pulses the next cycle; go to DROP.
  - s_last and the limit on the same beat is a normal end: no error.
  - m_ready low holds everything, including beat_cnt and the grant.
  - Non-granted s_valid are ignored and their data is held upstream.
- DROP:
  - s_ready[grant]=1 and m_valid=0; discard beats from the granted port.
  - A discarded beat with s_last returns to IDLE the next cycle.
- Width rules:
  - beat_cnt is $clog2(MAX_BEATS+1) bits and never wraps, because the limit caps it.
  - rr_ptr wraps modulo NUM_PORTS; non-power-of-2 counts must skip invalid codes.
- Invariants:
  - At most one s_ready is high.
  - m_port and grant only change in IDLE.
  - No beat is duplicated or lost except the beats discarded in DROP.

Test Plan:
- Single port: port 0 sends a 3-beat frame (idx 7,7,3), m_ready=1 → m_valid 1 cycle after s_valid, m_first on beat 0, m_last on beat 2 with m_idx=3, m_port=0, trunc_err=0.
- Contention: ports 0 and 1 both hold 2-beat frames continuously → order 0,1,0,1 with one idle cycle between frames; s_ready[1]=0 throughout port 0's frames.
- Backpressure: m_ready toggles 1,0,0,1 during a 4-beat frame → data stable while stalled, exactly 4 transfers, beat_cnt/m_first unaffected.
- Truncation: MAX_BEATS=4, port 1 sends a 7-beat frame → 4 beats out, m_last forced on beat 4, trunc_err pulse, 3 beats absorbed with m_valid=0, then IDLE.
- Boundary: 4-beat frame with s_last on beat 4 at MAX_BEATS=4 → normal end, trunc_err=0, no DROP.
- Reset mid-frame: assert rst after beat 2 of 5 → next cycle all s_ready=0, m_valid=0; the next grant goes to port 0.
